// File: rtl/proc_io_bridge_pkg.sv
// -----------------------------------------------------------------------------
// proc_io_bridge_pkg
//   Shared definitions for the processor IO bridge: channel-select width and
//   FIFO occupancy-count width helpers, and the bit positions used when the
//   two sticky status kinds are viewed together as a small packed vector.
// -----------------------------------------------------------------------------
package proc_io_bridge_pkg;

    // Width of a channel-select field for n channels (at least 1 bit).
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Occupancy counter width: must hold 0..depth inclusive.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Bit positions of the status kinds in a packed {unf, ovf} view.
    localparam int ST_OVF_POS = 0;
    localparam int ST_UNF_POS = 1;

endpackage

// File: rtl/proc_io_bridge_fifo.sv
// -----------------------------------------------------------------------------
// io_fifo
//   Single-clock first-word-fall-through FIFO used for every bridge channel.
//   Ports:
//     clk, rst   clock and synchronous active-high reset
//     push, din  write request and data; refused when full unless a pop is
//                accepted on the same edge
//     pop        read request; ignored when empty
//     dout       current head word, 0 when empty
//     full/empty occupancy flags
//     count      occupancy, 0..FDEPTH
// -----------------------------------------------------------------------------
module io_fifo
    import proc_io_bridge_pkg::*;
#(
    parameter int NUBITS = 16,
    parameter int FDEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic                            pop,
    input  logic [NUBITS-1:0]               din,
    output logic [NUBITS-1:0]               dout,
    output logic                            full,
    output logic                            empty,
    output logic [fifo_cnt_w(FDEPTH)-1:0]   count
);

    localparam int FDEPW = $clog2(FDEPTH);
    localparam int CW    = fifo_cnt_w(FDEPTH);

    logic [NUBITS-1:0] mem [FDEPTH];
    logic [FDEPW-1:0]  wr_ptr;
    logic [FDEPW-1:0]  rd_ptr;
    logic [CW-1:0]     cnt;
    logic              do_push;
    logic              do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(FDEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    // Storage is not reset; the head is masked by empty instead.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because FDEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = empty ? '0 : mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/proc_io_bridge.sv
// -----------------------------------------------------------------------------
// proc_io_bridge
//   Buffered multi-channel IO unit between the processor core IO port and
//   external streaming sources/sinks. One io_fifo per input channel and per
//   output channel.
//   Ports:
//     clk, rst           clock, synchronous active-high reset (drops all data)
//     io_in              head word of input FIFO addr_in (0 when empty)
//     addr_in, req_in    core read select / pop strobe
//     io_out             core write data
//     addr_out, out_en   core write select / push strobe
//     s_data/s_valid/s_ready   external input streams, channel k at
//                              s_data[k*NUBITS +: NUBITS]
//     m_data/m_valid/m_ready   external output streams, same packing
//     st_ovf             sticky: core write dropped on a full output FIFO
//     st_unf             sticky: core read of an empty input FIFO
//     st_clr             clears the sticky flags (a same-edge event wins)
//     io_stall           only when IO_STALL_EN is defined: the core must hold
//                        its strobes, addresses and data while it is high
//
//   Handshake: on every external channel a word moves on the rising edge where
//   valid && ready are both high. s_ready[k] means input FIFO k is not full;
//   m_valid[k] means output FIFO k is not empty, and m_data[k] (its head) is
//   held stable until the word is taken. Neither side waits on the other.
//
//   Optional build macro: IO_STALL_EN (stall the core instead of dropping
//   writes / returning zero on reads).
// -----------------------------------------------------------------------------
module proc_io_bridge
    import proc_io_bridge_pkg::*;
#(
    parameter int NUBITS = 16,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8,
    parameter int FDEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [NUBITS-1:0]           io_in,
    input  logic [chan_w(NUIOIN)-1:0]   addr_in,
    input  logic                        req_in,
    input  logic [NUBITS-1:0]           io_out,
    input  logic [chan_w(NUIOOU)-1:0]   addr_out,
    input  logic                        out_en,
    input  logic [NUIOIN*NUBITS-1:0]    s_data,
    input  logic [NUIOIN-1:0]           s_valid,
    output logic [NUIOIN-1:0]           s_ready,
    output logic [NUIOOU*NUBITS-1:0]    m_data,
    output logic [NUIOOU-1:0]           m_valid,
    input  logic [NUIOOU-1:0]           m_ready,
    output logic [NUIOOU-1:0]           st_ovf,
    output logic [NUIOIN-1:0]           st_unf,
    input  logic                        st_clr
`ifdef IO_STALL_EN
    ,
    output logic                        io_stall
`endif
);

    localparam int AIW   = chan_w(NUIOIN);
    localparam int AOW   = chan_w(NUIOOU);
    localparam int FDEPW = $clog2(FDEPTH);
    localparam int CW    = fifo_cnt_w(FDEPTH);

    logic [NUIOIN-1:0] rd_sel;
    logic [NUIOIN-1:0] in_push;
    logic [NUIOIN-1:0] in_full;
    logic [NUIOIN-1:0] in_empty;
    logic [NUIOIN-1:0] unf_evt;
    logic [NUBITS-1:0] in_head [NUIOIN];
    logic [CW-1:0]     in_cnt  [NUIOIN];

    logic [NUIOOU-1:0] wr_sel;
    logic [NUIOOU-1:0] out_push;
    logic [NUIOOU-1:0] out_full;
    logic [NUIOOU-1:0] out_empty;
    logic [NUIOOU-1:0] ovf_evt;
    logic [NUBITS-1:0] out_head [NUIOOU];
    logic [CW-1:0]     out_cnt  [NUIOOU];

    // ---------------- input channels: external push, core pop --------------
    for (genvar k = 0; k < NUIOIN; k++) begin : g_in
        assign rd_sel[k]  = req_in && (addr_in == AIW'(k));
        assign in_push[k] = s_valid[k] && !in_full[k];
        assign s_ready[k] = !in_full[k];

        io_fifo #(.NUBITS(NUBITS), .FDEPTH(FDEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (in_push[k]),
            .pop   (rd_sel[k]),
            .din   (s_data[k*NUBITS +: NUBITS]),
            .dout  (in_head[k]),
            .full  (in_full[k]),
            .empty (in_empty[k]),
            .count (in_cnt[k])
        );

        always_comb begin
            assert (in_full[k] == (in_cnt[k] == CW'(FDEPTH)));
        end
    end

    // ---------------- output channels: core push, external pop -------------
    for (genvar j = 0; j < NUIOOU; j++) begin : g_out
        assign wr_sel[j] = out_en && (addr_out == AOW'(j));
`ifdef IO_STALL_EN
        // A stalled write must not land, otherwise the held strobe would
        // push the same word twice once the stall lifts.
        assign out_push[j] = wr_sel[j] && !out_full[j];
`else
        assign out_push[j] = wr_sel[j];
`endif
        assign m_valid[j] = !out_empty[j];
        assign m_data[j*NUBITS +: NUBITS] = out_head[j];

        io_fifo #(.NUBITS(NUBITS), .FDEPTH(FDEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (out_push[j]),
            .pop   (m_ready[j]),
            .din   (io_out),
            .dout  (out_head[j]),
            .full  (out_full[j]),
            .empty (out_empty[j]),
            .count (out_cnt[j])
        );

        always_comb begin
            assert (out_empty[j] == (out_cnt[j] == '0));
        end
    end

    // ---------------- core read mux -----------------------------------------
    // Heads are already 0 when empty, so the mux needs no empty qualifier.
    always_comb begin
        io_in = '0;
        for (int i = 0; i < NUIOIN; i++) begin
            if (addr_in == AIW'(i)) begin
                io_in = in_head[i];
            end
        end
    end

    // ---------------- status events -----------------------------------------
`ifdef IO_STALL_EN
    assign io_stall = (|(rd_sel & in_empty)) || (|(wr_sel & out_full));
    assign unf_evt  = '0;
    assign ovf_evt  = '0;
`else
    assign unf_evt  = rd_sel & in_empty;
    // A write to a full FIFO only drops when the head is not leaving now.
    assign ovf_evt  = wr_sel & out_full & ~m_ready;
`endif

    // Clear first, then OR in new events so a coincident event wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_unf <= '0;
            st_ovf <= '0;
        end else begin
            st_unf <= (st_clr ? '0 : st_unf) | unf_evt;
            st_ovf <= (st_clr ? '0 : st_ovf) | ovf_evt;
        end
    end

endmodule

// File: tb/tb_proc_io_bridge.sv
// -----------------------------------------------------------------------------
// tb_proc_io_bridge
//   Directed scenarios followed by random traffic, checked every cycle against
//   a queue-based reference model of the bridge. Build with +define+IO_STALL_EN
//   to exercise the stalling variant.
// -----------------------------------------------------------------------------
module tb_proc_io_bridge;

    localparam int NB = 16;
    localparam int NI = 8;
    localparam int NO = 8;
    localparam int FD = 4;

    // ---------------- clock / reset ----------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NB-1:0]    io_in;
    logic [2:0]       addr_in;
    logic             req_in;
    logic [NB-1:0]    io_out;
    logic [2:0]       addr_out;
    logic             out_en;
    logic [NI*NB-1:0] s_data;
    logic [NI-1:0]    s_valid;
    logic [NI-1:0]    s_ready;
    logic [NO*NB-1:0] m_data;
    logic [NO-1:0]    m_valid;
    logic [NO-1:0]    m_ready;
    logic [NO-1:0]    st_ovf;
    logic [NI-1:0]    st_unf;
    logic             st_clr;
`ifdef IO_STALL_EN
    logic             io_stall;
`endif

    proc_io_bridge #(.NUBITS(NB), .NUIOIN(NI), .NUIOOU(NO), .FDEPTH(FD)) dut (
        .clk      (clk),
        .rst      (rst),
        .io_in    (io_in),
        .addr_in  (addr_in),
        .req_in   (req_in),
        .io_out   (io_out),
        .addr_out (addr_out),
        .out_en   (out_en),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .st_ovf   (st_ovf),
        .st_unf   (st_unf),
        .st_clr   (st_clr)
`ifdef IO_STALL_EN
        ,
        .io_stall (io_stall)
`endif
    );

    // ---------------- reference model ---------------------------------------
    logic [NB-1:0] in_q  [NI][$];
    logic [NB-1:0] out_q [NO][$];
    logic [NO-1:0] mdl_ovf;
    logic [NI-1:0] mdl_unf;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Applies one clock edge to the model using the currently driven inputs.
    task automatic model_edge();
        int  sz;
        bit  rd, wr, pop_ok, push_ok;
        if (rst) begin
            for (int k = 0; k < NI; k++) in_q[k].delete();
            for (int j = 0; j < NO; j++) out_q[j].delete();
            mdl_ovf = '0;
            mdl_unf = '0;
            return;
        end
        if (st_clr) begin
            mdl_ovf = '0;
            mdl_unf = '0;
        end
        for (int k = 0; k < NI; k++) begin
            sz      = in_q[k].size();
            rd      = req_in && (addr_in == 3'(k));
            pop_ok  = rd && (sz > 0);
            push_ok = s_valid[k] && (sz < FD);
`ifndef IO_STALL_EN
            if (rd && sz == 0) mdl_unf[k] = 1'b1;
`endif
            if (pop_ok)  void'(in_q[k].pop_front());
            if (push_ok) in_q[k].push_back(s_data[k*NB +: NB]);
        end
        for (int j = 0; j < NO; j++) begin
            sz     = out_q[j].size();
            wr     = out_en && (addr_out == 3'(j));
            pop_ok = m_ready[j] && (sz > 0);
`ifdef IO_STALL_EN
            push_ok = wr && (sz < FD);
`else
            push_ok = wr && ((sz < FD) || pop_ok);
            if (wr && !push_ok) mdl_ovf[j] = 1'b1;
`endif
            if (pop_ok)  void'(out_q[j].pop_front());
            if (push_ok) out_q[j].push_back(io_out);
        end
    endtask

    // Checks all outputs mid-cycle against the model, then takes one edge.
    task automatic tick();
        logic [NB-1:0]    e_io;
        logic [NI-1:0]    e_sr;
        logic [NO-1:0]    e_mv;
        logic [NO*NB-1:0] e_md;
        #2;
        e_io = (in_q[addr_in].size() > 0) ? in_q[addr_in][0] : '0;
        for (int k = 0; k < NI; k++) e_sr[k] = (in_q[k].size() < FD);
        for (int j = 0; j < NO; j++) begin
            e_mv[j] = (out_q[j].size() > 0);
            e_md[j*NB +: NB] = e_mv[j] ? out_q[j][0] : '0;
        end
        chk("io_in",   io_in,   e_io);
        chk("s_ready", s_ready, e_sr);
        chk("m_valid", m_valid, e_mv);
        chk("m_data",  m_data,  e_md);
        chk("st_ovf",  st_ovf,  mdl_ovf);
        chk("st_unf",  st_unf,  mdl_unf);
`ifdef IO_STALL_EN
        chk("io_stall", io_stall,
            (req_in && in_q[addr_in].size() == 0) || (out_en && out_q[addr_out].size() == FD));
`endif
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- stimulus ----------------------------------------------
    initial begin
        rst = 1'b1; addr_in = '0; req_in = 1'b0; io_out = '0; addr_out = '0;
        out_en = 1'b0; s_data = '0; s_valid = '0; m_ready = '0; st_clr = 1'b0;
        mdl_ovf = '0; mdl_unf = '0;

        @(posedge clk);
        model_edge();
        #1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_s_ready", s_ready, 8'hFF);
        chk("rst_m_valid", m_valid, 8'h00);
        chk("rst_io_in",   io_in,   16'h0000);
        chk("rst_flags",   {st_ovf, st_unf}, 16'h0000);

`ifndef IO_STALL_EN
        // External push on channel 3, then read it from the core.
        s_valid = 8'h08; s_data[3*NB +: NB] = 16'h1234;
        tick();
        s_valid = '0; addr_in = 3'd3;
        #1 chk("ch3_head", io_in, 16'h1234);
        req_in = 1'b1;
        tick();
        req_in = 1'b0;
        #1 chk("ch3_empty", io_in, 16'h0000);
        chk("ch3_no_unf", st_unf, 8'h00);

        // Underflow on empty channel 5, sticky, then cleared.
        addr_in = 3'd5; req_in = 1'b1;
        tick();
        req_in = 1'b0;
        #1 chk("unf5_set", st_unf, 8'h20);
        chk("unf5_zero_read", io_in, 16'h0000);
        tick();
        chk("unf5_sticky", st_unf, 8'h20);
        st_clr = 1'b1;
        tick();
        st_clr = 1'b0;
        #1 chk("unf5_clr", st_unf, 8'h00);

        // Five writes into output channel 2 with the sink stalled.
        addr_out = 3'd2; out_en = 1'b1; m_ready = '0;
        for (int i = 0; i < 5; i++) begin
            io_out = 16'hA000 + 16'(i);
            tick();
        end
        out_en = 1'b0;
        #1 chk("ovf2_set", st_ovf, 8'h04);
        m_ready = 8'h04;
        for (int i = 0; i < 4; i++) begin
            #1 chk("ch2_order", m_data[2*NB +: NB], 16'hA000 + 16'(i));
            tick();
        end
        m_ready = '0;
        #1 chk("ch2_drained", m_valid[2], 1'b0);

        // Full input channel 0: pop with s_valid held, no push that edge.
        s_valid = 8'h01;
        for (int i = 0; i < 4; i++) begin
            s_data[0 +: NB] = 16'h0C00 + 16'(i);
            tick();
        end
        addr_in = 3'd0; req_in = 1'b1;
        #1 chk("ch0_full", s_ready[0], 1'b0);
        tick();
        req_in = 1'b0;
        #1 chk("ch0_cnt3", s_ready[0], 1'b1);
        chk("ch0_head", io_in, 16'h0C01);
        tick();
        s_valid = '0;
        #1 chk("ch0_refull", s_ready[0], 1'b0);

        // Reset during a burst into output channel 1.
        addr_out = 3'd1; out_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            io_out = 16'hB000 + 16'(i);
            tick();
        end
        out_en = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 chk("mrst_m_valid", m_valid, 8'h00);
        chk("mrst_s_ready", s_ready, 8'hFF);
        chk("mrst_flags", {st_ovf, st_unf}, 16'h0000);
`else
        // Stalled read from empty channel 4 until an external push arrives.
        addr_in = 3'd4; req_in = 1'b1;
        tick();
        tick();
        #1 chk("stall_rd", io_stall, 1'b1);
        s_valid = 8'h10; s_data[4*NB +: NB] = 16'hBEEF;
        tick();
        s_valid = '0;
        #1 chk("stall_rel", io_stall, 1'b0);
        chk("stall_word", io_in, 16'hBEEF);
        tick();
        req_in = 1'b0;
        #1 chk("stall_no_unf", st_unf, 8'h00);
`endif

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            st_clr   = ($urandom_range(0, 15) == 0);
            req_in   = $urandom_range(0, 1);
            addr_in  = 3'($urandom_range(0, NI - 1));
            out_en   = $urandom_range(0, 1);
            addr_out = 3'($urandom_range(0, NO - 1));
            io_out   = 16'($urandom);
            s_valid  = 8'($urandom);
            m_ready  = 8'($urandom & $urandom);
            for (int k = 0; k < NI; k++) s_data[k*NB +: NB] = 16'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/proc_io_bridge.md
Name: proc_io_bridge

Overview:
- Multi-channel buffered IO unit between the fixed-point processor core's IO port and external streaming sources and sinks.
- The core-side signals (io_in, addr_in, req_in, io_out, addr_out, out_en) keep their existing meaning.
- Each input and output address gets its own FIFO with a valid/ready handshake on the external side.
- Decouples program timing from peripheral timing and reports overflow/underflow as sticky status.

Parameters:
- NUBITS, 16, data word width.
- NUIOIN, 8, number of input channels; must be ≥2.
- NUIOOU, 8, number of output channels; must be ≥2.
- FDEPTH, 4, words per channel FIFO; must be a power of two and ≥2.
- FDEPW, $clog2(FDEPTH), internal FIFO pointer width; derived, not set externally.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- io_in  out  NUBITS  data to core, head of the selected input FIFO.
- addr_in  in  $clog2(NUIOIN)  core input channel select.
- req_in  in  1  core read strobe; pops the selected input FIFO.
- io_out  in  NUBITS  data from core.
- addr_out  in  $clog2(NUIOOU)  core output channel select.
- out_en  in  1  core write strobe; pushes into the selected output FIFO.
- s_data  in  NUIOIN*NUBITS  external input words, channel k at bits [k*NUBITS +: NUBITS].
- s_valid  in  NUIOIN  per-channel input valid.
- s_ready  out  NUIOIN  per-channel input ready.
- m_data  out  NUIOOU*NUBITS  external output words.
- m_valid  out  NUIOOU  per-channel output valid.
- m_ready  in  NUIOOU  per-channel output ready.
- st_ovf  out  NUIOOU  sticky: core write dropped on a full output FIFO.
- st_unf  out  NUIOIN  sticky: core read from an empty input FIFO.
- st_clr  in  1  clears all sticky flags.

Behaviour:
- Reset: all FIFOs empty, pointers and counts 0. s_ready=all 1, m_valid=0, m_data=0, io_in=0, st_ovf=0, st_unf=0.
- rst is synchronous and active-high; a reset during any transfer discards all buffered data.
- External handshake:
  - A word transfers on the rising edge where valid && ready.
  - s_ready[k] = input FIFO k not full; m_valid[k] = output FIFO k not empty.
  - m_data[k] is the FIFO head and is held stable while m_valid && !m_ready.
- Core read (first-word-fall-through):
  - io_in = head of input FIFO addr_in, combinational from stored data. No external-to-core bypass.
  - req_in=1 pops at the clock edge.
  - If the FIFO is empty: io_in=0, no pop, and st_unf[addr_in] sets on that edge.
- Core write: out_en=1 pushes io_out into output FIFO addr_out at the clock edge. If full: the word is dropped and st_ovf[addr_out] sets.
- Simultaneous push and pop on one FIFO:
  - Full FIFO: both occur, count unchanged. External s_ready stays 0 that cycle, so only a core-side pop occurs on input FIFOs.
  - Empty FIFO: the push occurs and the pop is refused (underflow on input side). On the output side m_valid is already 0, so no pop occurs.
- Pointers wrap modulo FDEPTH. Counts are FDEPW+1 bits, range 0..FDEPTH.
- Sticky flags: st_clr clears on the edge. If st_clr and a new event coincide, the set wins.
- Latency: external push → visible on io_in the next cycle. Core write → m_valid the next cycle.

Optional Feature:
- Macro IO_STALL_EN.
- When defined:
  - Adds output io_stall (1 bit) = (req_in && selected input FIFO empty) || (out_en && selected output FIFO full).
  - The core must hold its strobes, address and data while io_stall=1.
  - No drop and no zero read occurs; st_ovf/st_unf are not set by stalled accesses.
- When undefined: io_stall does not exist, and the drop/zero-plus-sticky behaviour above applies.

Decomposition:
- Shared header proc_io_defs: channel-index width functions, FIFO count width, status bit positions.
- One sub-module io_fifo (NUBITS, FDEPTH):
  - push/pop, dout head, full, empty, count.
  - Push is refused when full, unless a pop happens in the same cycle.
- proc_io_bridge instantiates NUIOIN + NUIOOU io_fifo copies in generate loops and adds the core-side muxes and status logic.

Test Plan:
- Reset, then external push 0x1234 on input channel 3 → next cycle with addr_in=3: io_in=0x1234. req_in pop → channel 3 empty, st_unf=0.
- req_in with addr_in=5 while channel 5 is empty → io_in=0, st_unf[5]=1 and it stays 1. st_clr → 0.
- Core writes 5 words to output channel 2 with FDEPTH=4 and m_ready=0 → first 4 buffered, 5th dropped, st_ovf[2]=1. Raise m_ready → words emerge in order, then m_valid[2]=0.
- Full input channel 0 with req_in and s_valid both high → one pop, no push (s_ready[0]=0). Count becomes 3; the next cycle accepts the push.
- rst asserted mid-burst with 3 words in output channel 1 → next cycle m_valid=0, all counts 0, flags 0.
- With IO_STALL_EN: read from empty channel 4 → io_stall=1 until an external push. The held read then returns the pushed word, and st_unf[4] stays 0.
